// File: rtl/unit_l_pipe.sv
// Two-stage pipelined logic unit (PASS/AND/OR/XOR and their inversions) with
// valid/ready on both sides and a result-chaining mode. Optional zero/parity
// flags are built when UNIT_L_PIPE_FLAGS_EN is defined.
module unit_l_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_par
);

  // Handshake: a beat moves across a boundary on a cycle where the sender's
  // valid and the receiver's ready are both 1; valid and payload stay stable
  // until then. in_ready is combinational from out_ready, so a full pipe
  // accepts a new beat in the same cycle as its result leaves.
  logic             v1_q, v2_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic [2:0]       op1_q;
  logic             chain1_q;
  logic [WIDTH-1:0] data_q, lr_q;
  logic             en1, en2;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] res_d;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  always_comb begin
    b_eff = chain1_q ? lr_q : b1_q;
    base  = a1_q;
    case (op1_q[1:0])
      2'b00:   base = a1_q;
      2'b01:   base = a1_q & b_eff;
      2'b10:   base = a1_q | b_eff;
      default: base = a1_q ^ b_eff;
    endcase
    // op[2] inverts the f1f0 result: NOT a, NAND, NOR, XNOR.
    res_d = op1_q[2] ? ~base : base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      op1_q    <= 3'b000;
      chain1_q <= 1'b0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q     <= in_a;
        b1_q     <= in_b;
        op1_q    <= in_op;
        chain1_q <= in_chain;
      end
    end
  end

  // lr tracks the last result that entered S2, which in order is always the
  // beat immediately ahead of the one now sitting in S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      data_q <= '0;
      lr_q   <= '0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data_q <= res_d;
        lr_q   <= res_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data_q;

`ifdef UNIT_L_PIPE_FLAGS_EN
  logic zero_q, par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (en2 && v1_q) begin
      zero_q <= ~|res_d;
      par_q  <= ^res_d;
    end
  end

  assign out_zero = zero_q;
  assign out_par  = par_q;
`else
  assign out_zero = 1'b0;
  assign out_par  = 1'b0;
`endif

endmodule
